spi_opb_master: RTL

//  SPI-slave to OPB-master bridge; sole upstream driver of the OPB address decoder.
//  - Accepts framed read/write commands from the external host over SPI (mode 0).
//  - Issues single-cycle DEC_RE / DEC_WE strobes with DEC_ADDR.
//  - On reads, captures the decoder's registered DEC_DO and shifts it back out on MISO.

---
 rtl/spi_opb_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spi_opb_master.sv
// SPI-slave (mode 0) to OPB-master bridge: framed SPI commands become single-cycle
// DEC_RE / DEC_WE strobes, and captured read data is shifted back out on MISO.
module spi_opb_master #(
  parameter int SYNC_STAGES = 2,
  parameter int TURN_BITS   = 8
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        SPI_CS_N,
  input  logic        SPI_SCLK,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        SPI_MISO_OE,
  output logic        DEC_RE,
  output logic        DEC_WE,
  output logic [31:0] DEC_ADDR,
  output logic [31:0] DEC_DI,
  input  logic [31:0] DEC_DO,
  output logic        BUSY,
  output logic        FRAME_ERR
);
  localparam int CNT_MAX = (TURN_BITS > 32) ? TURN_BITS : 32;
  localparam int CW = $clog2(CNT_MAX + 1);
  // Chip select idles high so a reset never looks like a frame start.
  localparam logic [2:0] SYNC_RST = 3'b100;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, DATA_WR, ISSUE_WR, ISSUE_RD, CAPTURE, TURN, DATA_RD, WAIT_CS
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    async_in, synced;
  logic          cs_prev_reg, sclk_prev_reg;
  logic          cs_s, sclk_s, mosi_s, cs_fall, sclk_rise, sclk_fall;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   sr_reg, shift_full, addr_reg, tx_reg, dec_addr_reg, dec_di_reg;
  logic          is_rd_reg, miso_reg, frame_err_reg, frame_err_next;
  logic          last_cmd, last_word, last_turn;

  assign async_in = {SPI_CS_N, SPI_SCLK, SPI_MOSI};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
        else         chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
      end
      assign synced[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign cs_s       = synced[2];
  assign sclk_s     = synced[1];
  assign mosi_s     = synced[0];
  assign cs_fall    = cs_prev_reg & ~cs_s;
  assign sclk_rise  = sclk_s & ~sclk_prev_reg;
  assign sclk_fall  = ~sclk_s & sclk_prev_reg;
  assign shift_full = {sr_reg[30:0], mosi_s};
  assign last_cmd   = sclk_rise && (cnt_reg == CW'(7));
  assign last_word  = sclk_rise && (cnt_reg == CW'(31));
  assign last_turn  = sclk_rise && (cnt_reg == CW'(TURN_BITS - 1));

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // A final rise always wins over a simultaneous CS_N release so the frame completes.
  always_comb begin
    state_next     = state_reg;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE:     if (cs_fall) state_next = CMD;
      CMD: begin
        if (last_cmd) begin
          if (shift_full[6:0] != 7'd0) begin
            state_next     = WAIT_CS;
            frame_err_next = 1'b1;
          end else begin
            state_next = ADDR;
          end
        end else if (cs_s) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
        end
      end
      ADDR: begin
        if (last_word)  state_next = is_rd_reg ? ISSUE_RD : DATA_WR;
        else if (cs_s) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
        end
      end
      DATA_WR: begin
        if (last_word)  state_next = ISSUE_WR;
        else if (cs_s) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
        end
      end
      ISSUE_WR: state_next = cs_s ? IDLE : WAIT_CS;
      ISSUE_RD: state_next = CAPTURE;
      CAPTURE:  state_next = TURN;
      TURN: begin
        if (last_turn)  state_next = DATA_RD;
        else if (cs_s) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
        end
      end
      DATA_RD: begin
        if (last_word)  state_next = WAIT_CS;
        else if (cs_s) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
        end
      end
      WAIT_CS:  if (cs_s) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    DEC_RE      = (state_reg == ISSUE_RD);
    DEC_WE      = (state_reg == ISSUE_WR);
    BUSY        = (state_reg != IDLE);
    SPI_MISO_OE = ~cs_s;
    SPI_MISO    = miso_reg;
    FRAME_ERR   = frame_err_reg;
    DEC_ADDR    = dec_addr_reg;
    DEC_DI      = dec_di_reg;
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      cs_prev_reg   <= 1'b1;
      sclk_prev_reg <= 1'b0;
      cnt_reg       <= '0;
      sr_reg        <= '0;
      addr_reg      <= '0;
      tx_reg        <= '0;
      dec_addr_reg  <= '0;
      dec_di_reg    <= '0;
      is_rd_reg     <= 1'b0;
      miso_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      cs_prev_reg   <= cs_s;
      sclk_prev_reg <= sclk_s;
      frame_err_reg <= frame_err_next;
      if (state_next != state_reg) cnt_reg <= '0;
      else if (sclk_rise)          cnt_reg <= cnt_reg + CW'(1);
      if (sclk_rise && (state_reg == CMD || state_reg == ADDR || state_reg == DATA_WR))
        sr_reg <= shift_full;
      if (state_reg == CMD && state_next == ADDR) is_rd_reg <= sr_reg[6];
      if (state_reg == ADDR && state_next == DATA_WR) addr_reg <= shift_full;
      if (state_reg == ADDR && state_next == ISSUE_RD) dec_addr_reg <= shift_full;
      if (state_reg == DATA_WR && state_next == ISSUE_WR) begin
        dec_addr_reg <= addr_reg;
        dec_di_reg   <= shift_full;
      end
      // DEC_DO is valid during the cycle after the read strobe, i.e. while in CAPTURE.
      if (state_reg == CAPTURE)                  tx_reg <= DEC_DO;
      else if (state_reg == DATA_RD && sclk_fall) tx_reg <= {tx_reg[30:0], 1'b0};
      if (state_reg != DATA_RD)                  miso_reg <= 1'b0;
      else if (sclk_fall)                        miso_reg <= tx_reg[31];
    end
  end
endmodule
